aes_round_ctrl: RTL

Sequencing controller for the iterative AES-128 datapath, downstream of the round down-counter, which it replaces as the datapath's round source. Accepts one block via valid/ready, then issues one load cycle and NR round cycles. Per cycle it drives:
- round number
- round constant (rcon) to the key-schedule stage
- round-enable and final-round (skip MixColumns) strobes

It then presents completion on a valid/yumi handshake to the output register stage.

---
 rtl/aes_round_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Sequencing controller for the iterative AES-128 datapath. It accepts one
// block on a valid/ready handshake. It then issues one load cycle and NR
// round cycles. Completion is offered to the output stage on valid/yumi.
//
// Parameters:
//   NR             number of rounds, 10..14 (fits the 4-bit round field)
// Ports:
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   start_v_i      block valid from the input stage
//   start_ready_o  controller idle and able to accept a block
//   abort_i        synchronous abort back to idle (drops the current block)
//   load_o         load plaintext/key and apply the initial AddRoundKey
//   round_en_o     datapath performs one round this cycle
//   key_en_o       key schedule advances this cycle (same as round_en_o)
//   final_round_o  last round; MixColumns is bypassed
//   round_o        current round number (0 in idle/load, NR while done)
//   rcon_o         round constant for the key schedule (0 outside rounds)
//   busy_o         load or round phase in progress
//   done_v_o       ciphertext valid at the datapath output
//   done_yumi_i    downstream consumed the result
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_v_i,
  output logic       start_ready_o,
  input  logic       abort_i,
  output logic       load_o,
  output logic       round_en_o,
  output logic       key_en_o,
  output logic       final_round_o,
  output logic [3:0] round_o,
  output logic [7:0] rcon_o,
  output logic       busy_o,
  output logic       done_v_o,
  input  logic       done_yumi_i
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_e;

  state_e     state;
  logic [3:0] round_q;
  logic [7:0] rcon_q;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Abort is checked before the per-state decisions. This gives it priority
  // over start, over the round advance and over yumi.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else if (abort_i) begin
      state   <= S_IDLE;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_v_i) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          state   <= S_ROUND;
          round_q <= 4'd1;
          rcon_q  <= 8'h01;
        end
        S_ROUND: begin
          if (round_q == LAST_ROUND) begin
            state <= S_DONE;
          end else begin
            round_q <= round_q + 4'd1;
            rcon_q  <= xtime(rcon_q);
          end
        end
        S_DONE: begin
          if (done_yumi_i) begin
            state   <= S_IDLE;
            round_q <= '0;
            rcon_q  <= 8'h01;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Every output is decoded from the state, round and rcon registers only.
  // No input reaches an output through a combinational path.
  always_comb begin
    start_ready_o = (state == S_IDLE);
    load_o        = (state == S_LOAD);
    round_en_o    = (state == S_ROUND);
    key_en_o      = (state == S_ROUND);
    final_round_o = (state == S_ROUND) && (round_q == LAST_ROUND);
    round_o       = ((state == S_ROUND) || (state == S_DONE)) ? round_q : '0;
    rcon_o        = (state == S_ROUND) ? rcon_q : 8'h00;
    busy_o        = (state == S_LOAD) || (state == S_ROUND);
    done_v_o      = (state == S_DONE);
  end

endmodule
